gray_to_bin_seq: RTL and testbench

//  Bit-serial Gray-to-binary decoder; inverse of the team's binary-to-Gray converter.

---
 rtl/g2b_pkg.sv | 24 ++
 rtl/g2b_xor_stage.sv | 13 +
 rtl/gray_to_bin_seq.sv | 127 ++++++++++++
 tb/tb_gray_to_bin_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/g2b_pkg.sv
// Shared definitions for the bit-serial Gray-to-binary decoder: FSM encodings
// and a combinational reference decode used by the bench.
package g2b_pkg;

  localparam int G2B_MAX_W = 16;

  typedef enum logic [1:0] {
    G2B_IDLE = 2'd0,
    G2B_CONV = 2'd1,
    G2B_DONE = 2'd2
  } g2b_state_t;

  // Zero-extended narrower words decode correctly: leading zeros stay zero.
  function automatic logic [G2B_MAX_W-1:0] g2b_ref(input logic [G2B_MAX_W-1:0] gray);
    logic [G2B_MAX_W-1:0] b;
    b = '0;
    b[G2B_MAX_W-1] = gray[G2B_MAX_W-1];
    for (int i = G2B_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ gray[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/g2b_xor_stage.sv
// One step of the Gray-to-binary chain: next binary bit from the bit above
// and the matching Gray bit.
module g2b_xor_stage
  import g2b_pkg::*;
(
  input  logic bin_hi,
  input  logic g_bit,
  output logic bin_bit
);

  assign bin_bit = bin_hi ^ g_bit;

endmodule

// File: rtl/gray_to_bin_seq.sv
// Bit-serial Gray-to-binary decoder, MSB first, valid/ready on both sides.
// Define G2B_DUAL_STEP_EN to resolve two bits per CONV cycle instead of one.
module gray_to_bin_seq
  import g2b_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] bin_out,
  output logic             busy
);

  localparam int IW = $clog2(WIDTH);

  g2b_state_t       state, state_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  // The MSB of the Gray word is consumed at accept, so only the lower bits are kept.
  logic [WIDTH-2:0] g_reg, g_nxt;
  logic [WIDTH-1:0] bin_reg, bin_nxt;
  logic             hi_bit, g_bit0, res0;
`ifdef G2B_DUAL_STEP_EN
  logic             g_bit1, res1;
`endif

  // Operand select for the XOR chain at the current index.
  always_comb begin
    hi_bit = 1'b0;
    g_bit0 = 1'b0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (int'(idx) == i) begin
        hi_bit = bin_reg[i+1];
        g_bit0 = g_reg[i];
      end
    end
  end

`ifdef G2B_DUAL_STEP_EN
  always_comb begin
    g_bit1 = 1'b0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (int'(idx) == i + 1) g_bit1 = g_reg[i];
    end
  end
`endif

  g2b_xor_stage u_stage0 (
    .bin_hi (hi_bit),
    .g_bit  (g_bit0),
    .bin_bit(res0)
  );

`ifdef G2B_DUAL_STEP_EN
  g2b_xor_stage u_stage1 (
    .bin_hi (res0),
    .g_bit  (g_bit1),
    .bin_bit(res1)
  );
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    g_nxt     = g_reg;
    bin_nxt   = bin_reg;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      G2B_IDLE: begin
        in_ready = ~rst;
        if (in_valid) begin
          g_nxt              = gray_in[WIDTH-2:0];
          bin_nxt[WIDTH-1]   = gray_in[WIDTH-1];
          idx_nxt            = IW'(WIDTH - 2);
          state_nxt          = G2B_CONV;
        end
      end
      G2B_CONV: begin
        busy = 1'b1;
        for (int i = 0; i < WIDTH - 1; i++) begin
          if (int'(idx) == i) bin_nxt[i] = res0;
`ifdef G2B_DUAL_STEP_EN
          if (int'(idx) == i + 1) bin_nxt[i] = res1;
`endif
        end
`ifdef G2B_DUAL_STEP_EN
        // Stop before idx would pass below zero; idx==0 resolves b[0] alone.
        if (idx <= IW'(1)) state_nxt = G2B_DONE;
        else               idx_nxt   = idx - IW'(2);
`else
        if (idx == '0) state_nxt = G2B_DONE;
        else           idx_nxt   = idx - IW'(1);
`endif
      end
      G2B_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        // A waiting input word is taken in the following IDLE cycle, not here.
        if (out_ready) state_nxt = G2B_IDLE;
      end
      default: state_nxt = G2B_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= G2B_IDLE;
      idx     <= '0;
      g_reg   <= '0;
      bin_reg <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      g_reg   <= g_nxt;
      bin_reg <= bin_nxt;
    end
  end

  assign bin_out = bin_reg;

endmodule

// File: tb/tb_gray_to_bin_seq.sv
// Directed bench for gray_to_bin_seq with a scoreboard of expected binary words.
module tb_gray_to_bin_seq;
  import g2b_pkg::*;

  localparam int W = 4;
`ifdef G2B_DUAL_STEP_EN
  localparam int LAT = 1 + W / 2;
`else
  localparam int LAT = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] gray_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] bin_out;
  logic         busy;

  int nassert = 0;
  int nfail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] words[6] = '{4'h5, 4'hA, 4'hF, 4'h1, 4'hC, 4'h7};

  always #5 clk = ~clk;

  gray_to_bin_seq #(.WIDTH(W)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .gray_in  (gray_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .bin_out  (bin_out),
    .busy     (busy)
  );

`ifdef G2B_DUAL_STEP_EN
  logic       in_valid5, in_ready5, out_valid5, out_ready5, busy5;
  logic [4:0] gray_in5, bin_out5;

  gray_to_bin_seq #(.WIDTH(5)) u_dut5 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid5),
    .in_ready (in_ready5),
    .gray_in  (gray_in5),
    .out_valid(out_valid5),
    .out_ready(out_ready5),
    .bin_out  (bin_out5),
    .busy     (busy5)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_w(input logic [W-1:0] g);
    logic [G2B_MAX_W-1:0] r;
    r = g2b_ref(G2B_MAX_W'(g));
    return r[W-1:0];
  endfunction

  task automatic pop_chk(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_underflow"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(bin_out), 32'(e));
    end
  endtask

  // One full transaction; optionally stall the output and present a new word meanwhile.
  task automatic convert(input logic [W-1:0] g, input logic [W-1:0] exp,
                         input int hold, input bit pend);
    int lat;
    @(negedge clk);
    gray_in   = g;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
    gray_in  = ~g;
    lat = 1;
    while (!out_valid && lat < 4 * W + 4) begin
      chk("conv_in_ready", 32'(in_ready), 32'd0);
      chk("conv_busy", 32'(busy), 32'd1);
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(LAT));
    chk("done_busy", 32'(busy), 32'd1);
    for (int c = 0; c < hold; c++) begin
      if (pend) begin
        in_valid = 1'b1;
        gray_in  = g ^ W'(c + 1);
      end
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(bin_out), 32'(exp));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("done_valid", 32'(out_valid), 32'd1);
    pop_chk("data");
    @(negedge clk);
    out_ready = 1'b0;
    chk("drop_valid", 32'(out_valid), 32'd0);
    chk("back_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    int sent, rcvd, cyc, last_out, last_acc, lat;
    bit adv;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    gray_in   = '0;
`ifdef G2B_DUAL_STEP_EN
    in_valid5  = 1'b0;
    out_ready5 = 1'b0;
    gray_in5   = '0;
`endif
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_bin_out", 32'(bin_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    convert(4'b0110, 4'b0100, 0, 1'b0);
    convert(4'b1000, 4'b1111, 0, 1'b0);
    convert(4'b0000, 4'b0000, 0, 1'b0);
    convert(4'b1011, 4'b1101, 5, 1'b1);

    // Reset during the second CONV cycle discards the word.
    @(negedge clk);
    gray_in  = 4'b1010;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_bin_out", 32'(bin_out), 32'd0);
    chk("midrst_busy_clr", 32'(busy), 32'd0);
    convert(4'b0011, 4'b0010, 0, 1'b0);

    for (int i = 0; i < 16; i++) convert(W'(i), ref_w(W'(i)), 0, 1'b0);

    // Streaming with both handshakes held high.
    sent = 0; rcvd = 0; cyc = 0; last_out = -1; last_acc = -1; adv = 1'b0;
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    gray_in   = words[0];
    while (rcvd < 6 && cyc < 200) begin
      if (out_valid) begin
        pop_chk("b2b_data");
        if (last_out >= 0) chk("b2b_out_period", 32'(cyc - last_out), 32'(LAT + 1));
        last_out = cyc;
        rcvd++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_w(words[sent]));
        if (last_acc >= 0) chk("b2b_acc_period", 32'(cyc - last_acc), 32'(LAT + 1));
        last_acc = cyc;
        sent++;
        adv = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (adv) begin
        adv = 1'b0;
        if (sent < 6) gray_in = words[sent];
        else          in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("b2b_count", 32'(rcvd), 32'd6);
    chk("b2b_sent", 32'(sent), 32'd6);
    chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef G2B_DUAL_STEP_EN
    @(negedge clk);
    gray_in5   = 5'b11010;
    in_valid5  = 1'b1;
    out_ready5 = 1'b1;
    @(negedge clk);
    in_valid5 = 1'b0;
    lat = 1;
    while (!out_valid5 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("w5_latency", 32'(lat), 32'd3);
    chk("w5_data", 32'(bin_out5), 32'h13);
    @(negedge clk);
    chk("w5_drop_valid", 32'(out_valid5), 32'd0);
    out_ready5 = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
